ram_bist: RTL and testbench

- Built-in self-test initiator for the single-port synchronous RAM. It drives the RAM's address, write-data and write-enable inputs, and checks the read data that comes back.
- Runs a fixed four-element March sequence over the whole address space using a programmable background pattern.
- Reports pass/fail, the first failing address and data, and an error count.
- Sits between the test/debug controller and the RAM's port. The system mux that selects it is outside this block.

---
 rtl/ram_bist.sv | 203 ++++++++++++++++++++
 tb/tb_ram_bist.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// March BIST initiator for a single-port synchronous RAM.
// Runs W0(P) / R0W1 up / R1W0 down / R0 up over the full address space and
// reports pass/fail, first failing address/data and a saturating error count.
module ram_bist #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ERR_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] pattern_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_write_enable_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_data_o,
  output logic [ERR_W-1:0]  err_count_o
);

  typedef enum logic [2:0] {
    StIdle,
    StW0,
    StR0W1,
    StR1W0,
    StR0,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] AddrMax = '1;
  localparam logic [ERR_W-1:0]  ErrMax  = '1;

  state_e            state_q, state_d;
  logic              ck_q, ck_d;          // 0 = RD cycle, 1 = CK cycle
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic              check_en;
  logic [DATA_W-1:0] expected;

  // Next-state, RAM drive and miscompare bookkeeping.
  always_comb begin
    state_d     = state_q;
    ck_d        = ck_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    pat_d       = pat_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    err_d       = err_q;

    // Read data for the address of the RD cycle arrives during its CK cycle.
    check_en = ck_q && ((state_q == StR0W1) || (state_q == StR1W0) || (state_q == StR0));
    expected = (state_q == StR1W0) ? ~pat_q : pat_q;

    if (check_en && (ram_data_i != expected)) begin
      if (err_q == '0) begin
        fail_addr_d = addr_q;
        fail_data_d = ram_data_i;
      end
      if (err_q != ErrMax) begin
        err_d = err_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          pat_d       = pattern_i;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          err_d       = '0;
          busy_d      = 1'b1;
          state_d     = StW0;
          addr_d      = '0;
          ck_d        = 1'b0;
          we_d        = 1'b1;
          wdata_d     = pattern_i;
        end
      end
      StW0: begin
        if (addr_q == AddrMax) begin
          state_d = StR0W1;
          addr_d  = '0;
          ck_d    = 1'b0;
        end else begin
          addr_d  = addr_q + 1'b1;
          we_d    = 1'b1;
          wdata_d = pat_q;
        end
      end
      StR0W1: begin
        if (!ck_q) begin
          ck_d    = 1'b1;
          we_d    = 1'b1;
          wdata_d = ~pat_q;
        end else begin
          ck_d = 1'b0;
          if (addr_q == AddrMax) begin
            state_d = StR1W0;
            addr_d  = AddrMax;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StR1W0: begin
        if (!ck_q) begin
          ck_d    = 1'b1;
          we_d    = 1'b1;
          wdata_d = pat_q;
        end else begin
          ck_d = 1'b0;
          if (addr_q == '0) begin
            state_d = StR0;
            addr_d  = '0;
          end else begin
            addr_d = addr_q - 1'b1;
          end
        end
      end
      StR0: begin
        if (!ck_q) begin
          ck_d = 1'b1;
        end else begin
          ck_d = 1'b0;
          if (addr_q == AddrMax) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // err_d already includes this final check.
            pass_d  = (err_d == '0);
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ck_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      pat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      ck_q        <= ck_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      pat_q       <= pat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      err_q       <= err_d;
    end
  end

  assign ram_addr_o         = addr_q;
  assign ram_data_o         = wdata_q;
  assign ram_write_enable_o = we_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;
  assign fail_addr_o        = fail_addr_q;
  assign fail_data_o        = fail_data_q;
  assign err_count_o        = err_q;

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench for ram_bist with a faultable behavioural RAM.
module tb_ram_bist;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int ERR_W  = 4;
  localparam int D      = 1 << ADDR_W;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic [DATA_W-1:0] pattern_i = '0;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_data_o;
  logic              ram_write_enable_o;
  logic [DATA_W-1:0] ram_data_i;
  logic              busy_o, done_o, pass_o;
  logic [ADDR_W-1:0] fail_addr_o;
  logic [DATA_W-1:0] fail_data_o;
  logic [ERR_W-1:0]  err_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  ram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .start_i            (start_i),
    .pattern_i          (pattern_i),
    .ram_addr_o         (ram_addr_o),
    .ram_data_o         (ram_data_o),
    .ram_write_enable_o (ram_write_enable_o),
    .ram_data_i         (ram_data_i),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .pass_o             (pass_o),
    .fail_addr_o        (fail_addr_o),
    .fail_data_o        (fail_data_o),
    .err_count_o        (err_count_o)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: mode 0 clean, 1 stuck-at-0 bit, 2 inverted reads.
  logic [DATA_W-1:0] mem [D];
  logic [DATA_W-1:0] rd_q = '0;
  int                f_mode = 0;
  int                f_addr = 0;
  int                f_bit  = 0;
  logic [DATA_W-1:0] wr_val;

  initial for (int i = 0; i < D; i++) mem[i] = '0;

  always_comb begin
    wr_val = ram_data_o;
    if (f_mode == 1 && int'(ram_addr_o) == f_addr) wr_val[f_bit] = 1'b0;
  end

  always @(posedge clk) begin
    if (ram_write_enable_o) mem[ram_addr_o] <= wr_val;
    else rd_q <= (f_mode == 2) ? ~mem[ram_addr_o] : mem[ram_addr_o];
  end
  assign ram_data_i = rd_q;

  // Busy-cycle trace sampled mid-cycle.
  int                busy_cnt = 0;
  logic [ADDR_W-1:0] tr_addr[$];
  logic              tr_we[$];
  logic [DATA_W-1:0] tr_data[$];

  always @(negedge clk) begin
    if (busy_o) begin
      busy_cnt <= busy_cnt + 1;
      tr_addr.push_back(ram_addr_o);
      tr_we.push_back(ram_write_enable_o);
      tr_data.push_back(ram_data_o);
    end
  end

  // Expected port activity of a whole run, cycle by cycle from the march description.
  function automatic int trace_errors(input logic [DATA_W-1:0] p, input int base);
    int bad = 0;
    if (tr_addr.size() - base < 7 * D) return 7 * D;
    for (int i = 0; i < 7 * D; i++) begin
      int ea; logic ew; logic [DATA_W-1:0] ed;
      if (i < D) begin
        ea = i; ew = 1'b1; ed = p;
      end else begin
        int j = i - D;
        int e = j / (2 * D);
        int k = j % (2 * D);
        ew = (e != 2) && (k % 2 == 1);
        ea = (e == 1) ? D - 1 - k / 2 : k / 2;
        ed = (e == 0) ? ~p : p;
      end
      if (int'(tr_addr[base+i]) != ea || tr_we[base+i] !== ew ||
          (ew && tr_data[base+i] !== ed)) bad++;
    end
    return bad;
  endfunction

  // Abstract march over an array with the same fault: raw miscompares and first failure.
  function automatic void march_ref(input logic [DATA_W-1:0] p, input int mode, input int fa,
                                    input int fb, output int errs, output int faddr,
                                    output logic [DATA_W-1:0] fdata);
    logic [DATA_W-1:0] m [D];
    errs = 0; faddr = 0; fdata = '0;
    for (int e = 0; e < 4; e++) begin
      for (int k = 0; k < D; k++) begin
        int a = (e == 2) ? D - 1 - k : k;
        logic [DATA_W-1:0] w, obs, ex;
        if (e == 0) begin
          w = p;
        end else begin
          ex  = (e == 2) ? ~p : p;
          obs = (mode == 2) ? ~m[a] : m[a];
          if (obs !== ex) begin
            if (errs == 0) begin faddr = a; fdata = obs; end
            errs++;
          end
          w = (e == 1) ? ~p : (e == 2) ? p : m[a];
        end
        if (e != 3) begin
          if (mode == 1 && a == fa) w[fb] = 1'b0;
          m[a] = w;
        end
      end
    end
  endfunction

  task automatic run_march(input logic [DATA_W-1:0] p, input bit hold, output bit timed_out,
                           output int base, output int b0);
    @(negedge clk);
    base = tr_addr.size();
    b0 = busy_cnt;
    pattern_i = p;
    start_i = 1'b1;
    @(negedge clk);
    if (!hold) start_i = 1'b0;
    pattern_i = $urandom;
    timed_out = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      if (done_o) begin timed_out = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
    n_checks++; if (pass_o !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b want 0", pass_o); end
    n_checks++; if (ram_write_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", ram_write_enable_o); end
    n_checks++; if (ram_addr_o !== '0 || ram_data_o !== '0) begin n_fail++; $display("FAIL reset_ram got %h/%h want 0/0", ram_addr_o, ram_data_o); end
    n_checks++; if (err_count_o !== '0 || fail_addr_o !== '0 || fail_data_o !== '0) begin
      n_fail++; $display("FAIL reset_err got %h/%h/%h want 0", err_count_o, fail_addr_o, fail_data_o);
    end
  endtask

  task automatic test_fault_free;
    logic [DATA_W-1:0] p;
    bit to; int base, b0, bad, te;
    for (int r = 0; r < 2; r++) begin
      p = (r == 0) ? 32'hA5A5_5A5A : $urandom;
      f_mode = 0;
      run_march(p, 1'b0, to, base, b0);
      n_checks++; if (to) begin n_fail++; $display("FAIL ff_timeout got no done want done"); end
      n_checks++; if (busy_cnt - b0 != 7 * D) begin n_fail++; $display("FAIL ff_busy_len got %0d want %0d", busy_cnt - b0, 7 * D); end
      n_checks++; if (pass_o !== 1'b1 || err_count_o !== '0) begin
        n_fail++; $display("FAIL ff_pass got pass=%b err=%0d want 1/0", pass_o, err_count_o);
      end
      te = trace_errors(p, base);
      n_checks++; if (te != 0) begin n_fail++; $display("FAIL ff_trace got %0d bad cycles want 0", te); end
      bad = 0;
      for (int a = 0; a < D; a++) if (mem[a] !== p) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ff_final_mem got %0d bad words want 0", bad); end
    end
  endtask

  task automatic test_stuck_bit;
    logic [DATA_W-1:0] p, fd;
    bit to; int base, b0, errs, fa;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) begin p = 32'hFFFF_FFFF; f_addr = 'h37; f_bit = 0; end
      else begin p = $urandom | 32'h1; f_addr = $urandom_range(D - 1); f_bit = 0; end
      f_mode = 1;
      march_ref(p, 1, f_addr, f_bit, errs, fa, fd);
      run_march(p, 1'b0, to, base, b0);
      n_checks++; if (to || done_o !== 1'b1) begin n_fail++; $display("FAIL sa_done got %b want 1", done_o); end
      n_checks++; if (int'(err_count_o) != ((errs > ERR_MAX) ? ERR_MAX : errs) || pass_o !== (errs == 0)) begin
        n_fail++; $display("FAIL sa_err got err=%0d pass=%b want err=%0d pass=%b", err_count_o, pass_o, errs, errs == 0);
      end
      n_checks++; if (int'(fail_addr_o) != fa || fail_data_o !== fd) begin
        n_fail++; $display("FAIL sa_first got %h/%h want %h/%h", fail_addr_o, fail_data_o, fa, fd);
      end
    end
    f_mode = 0;
  endtask

  task automatic test_write_order;
    bit to; int base, b0, bad, te;
    f_mode = 0;
    run_march('0, 1'b0, to, base, b0);
    bad = 0;
    if (tr_addr.size() - base < 7 * D) bad = 1;
    else begin
      for (int k = 0; k < 2 * D; k++) begin
        int i = base + 3 * D + k;
        if (int'(tr_addr[i]) != D - 1 - k / 2) bad++;
        if ((k % 2 == 1) && (tr_we[i] !== 1'b1 || tr_data[i] !== '0)) bad++;
        if ((k % 2 == 0) && tr_we[i] !== 1'b0) bad++;
      end
    end
    n_checks++; if (to || bad != 0) begin n_fail++; $display("FAIL wo_r1w0 got %0d bad cycles want 0", bad); end
    te = trace_errors('0, base);
    n_checks++; if (te != 0) begin n_fail++; $display("FAIL wo_trace got %0d bad cycles want 0", te); end
  endtask

  task automatic test_start_held;
    bit to; int base, b0;
    logic [DATA_W-1:0] p = $urandom;
    f_mode = 0;
    run_march(p, 1'b1, to, base, b0);
    n_checks++; if (to || busy_cnt - b0 != 7 * D) begin
      n_fail++; $display("FAIL sh_busy_len got %0d want %0d", busy_cnt - b0, 7 * D);
    end
    @(negedge clk);
    n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL sh_restart got done=%b busy=%b want 0/1", done_o, busy_o);
    end
    start_i = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      if (done_o) begin to = 1'b0; break; end
      @(negedge clk);
    end
    n_checks++; if (to || pass_o !== 1'b1) begin n_fail++; $display("FAIL sh_second got pass=%b want 1", pass_o); end
  endtask

  task automatic test_reset_mid;
    bit to; int base, b0, wes;
    f_mode = 0;
    @(negedge clk);
    pattern_i = $urandom;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (599) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    n_checks++; if (busy_o !== 0 || done_o !== 0 || pass_o !== 0 || ram_write_enable_o !== 0 ||
                    ram_addr_o !== '0 || ram_data_o !== '0 || err_count_o !== '0 ||
                    fail_addr_o !== '0 || fail_data_o !== '0) begin
      n_fail++; $display("FAIL rm_zero got busy=%b done=%b we=%b addr=%h data=%h want all 0",
                         busy_o, done_o, ram_write_enable_o, ram_addr_o, ram_data_o);
    end
    wes = 0;
    repeat (20) begin @(negedge clk); if (ram_write_enable_o !== 1'b0 || busy_o !== 1'b0) wes++; end
    n_checks++; if (wes != 0) begin n_fail++; $display("FAIL rm_quiet got %0d active cycles want 0", wes); end
    run_march($urandom, 1'b0, to, base, b0);
    n_checks++; if (to || busy_cnt - b0 != 7 * D || pass_o !== 1'b1) begin
      n_fail++; $display("FAIL rm_rerun got len=%0d pass=%b want %0d/1", busy_cnt - b0, pass_o, 7 * D);
    end
  endtask

  task automatic test_invert_reads;
    logic [DATA_W-1:0] p, fd;
    bit to; int base, b0, errs, fa;
    p = $urandom;
    f_mode = 2;
    march_ref(p, 2, 0, 0, errs, fa, fd);
    run_march(p, 1'b0, to, base, b0);
    n_checks++; if (to || int'(err_count_o) != ((errs > ERR_MAX) ? ERR_MAX : errs) || pass_o !== 1'b0) begin
      n_fail++; $display("FAIL inv_sat got err=%0d pass=%b want %0d/0", err_count_o, pass_o, ERR_MAX);
    end
    n_checks++; if (int'(fail_addr_o) != fa || fail_data_o !== fd) begin
      n_fail++; $display("FAIL inv_first got %h/%h want %h/%h", fail_addr_o, fail_data_o, fa, fd);
    end
    f_mode = 0;
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_bit();
    test_write_order();
    test_start_held();
    test_reset_mid();
    test_invert_reads();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
